// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit packetizer.
// Header byte counts feed the UDP/IP length fields computed at launch.
package udp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LAUNCH,
    S_WAIT_TX,
    S_ABORT,
    S_GAP
  } state_t;

  localparam logic [15:0] MAGIC             = 16'hA55A;
  localparam logic [15:0] UDP_HDR_BYTES     = 16'd8;
  localparam logic [15:0] IP_UDP_HDR_BYTES  = 16'd28;
  localparam int          MAX_PAYLOAD_BYTES = 1472;

  // UDP payload bytes for a packet of 'words' data words plus the header word.
  function automatic logic [15:0] payload_bytes(input logic [15:0] words);
    return 16'((words + 16'd1) << 3);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, asynchronous active-low reset to RST_VAL.
// Latency 2 clk; no flow control.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/udp_tx_packer.sv
// Packs 64-bit samples behind a header word into the Ethernet TX FIFO and launches them.
// Header/sample writes are combinational on accept; backpressure via etx_full gates every write.
module udp_tx_packer #(
  parameter int          WORDS_PER_PKT = 128,
  parameter logic [15:0] MAGIC         = udp_pkg::MAGIC,
  parameter int          IFG_CYCLES    = 64,
  parameter int          TX_TIMEOUT    = 65535,
  parameter int          RST_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [63:0] sample_data,
  output logic        sample_ready,
  input  logic        flush,
  input  logic        etx_full,
  input  logic        etx_empty,
  output logic [63:0] etx_din,
  output logic        wr_en,
  output logic        tx_enable,
  output logic [15:0] tx_data_length,
  output logic [15:0] tx_total_length,
  output logic        etx_fifo_rst,
  output logic [15:0] seq_num,
  output logic        pkt_sent,
  output logic [7:0]  timeout_cnt
);

  import udp_pkg::*;

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic [31:0] tmr, tmr_nxt;
  logic        seen_ne, seen_ne_nxt;
  logic        empty_s, hs;
  logic [15:0] seq_nxt, data_len_nxt, total_len_nxt, pay;
  logic        tx_en_nxt, sent_nxt;
  logic [7:0]  tmo_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_empty_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (etx_empty),
    .q       (empty_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    tmr_nxt       = tmr + 32'd1;
    seen_ne_nxt   = seen_ne;
    seq_nxt       = seq_num;
    data_len_nxt  = tx_data_length;
    total_len_nxt = tx_total_length;
    tx_en_nxt     = tx_enable;
    sent_nxt      = 1'b0;
    tmo_nxt       = timeout_cnt;
    sample_ready  = 1'b0;
    wr_en         = 1'b0;
    etx_din       = '0;
    etx_fifo_rst  = 1'b0;
    hs            = 1'b0;
    pay           = payload_bytes({8'h00, count});
    case (state)
      S_IDLE: begin
        // Header goes in first; the triggering sample stays pending for FILL.
        if (sample_valid && !etx_full) begin
          wr_en     = 1'b1;
          etx_din   = {MAGIC, seq_num, 32'h0};
          count_nxt = '0;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        sample_ready = !etx_full;
        hs           = sample_valid && sample_ready;
        if (hs) begin
          wr_en     = 1'b1;
          etx_din   = sample_data;
          count_nxt = 8'(count + 8'd1);
        end
        if (count_nxt == 8'(WORDS_PER_PKT) || flush) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        data_len_nxt  = pay + UDP_HDR_BYTES;
        total_len_nxt = pay + IP_UDP_HDR_BYTES;
        tx_en_nxt     = 1'b1;
        tmr_nxt       = '0;
        seen_ne_nxt   = 1'b0;
        state_nxt     = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        // Completion needs non-empty then empty, so a stale empty cannot end the packet.
        if (!empty_s) seen_ne_nxt = 1'b1;
        if (seen_ne && empty_s) begin
          tx_en_nxt = 1'b0;
          sent_nxt  = 1'b1;
          seq_nxt   = seq_num + 16'd1;
          tmr_nxt   = '0;
          state_nxt = S_GAP;
        end else if (tmr == 32'(TX_TIMEOUT - 1)) begin
          tx_en_nxt = 1'b0;
          seq_nxt   = seq_num + 16'd1;
          if (timeout_cnt != 8'hFF) tmo_nxt = timeout_cnt + 8'd1;
          tmr_nxt   = '0;
          state_nxt = S_ABORT;
        end
      end
      S_ABORT: begin
        etx_fifo_rst = 1'b1;
        if (tmr == 32'(RST_CYCLES - 1)) begin
          tmr_nxt   = '0;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr == 32'(IFG_CYCLES - 1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count           <= '0;
      tmr             <= '0;
      seen_ne         <= 1'b0;
      seq_num         <= '0;
      tx_data_length  <= '0;
      tx_total_length <= '0;
      tx_enable       <= 1'b0;
      pkt_sent        <= 1'b0;
      timeout_cnt     <= '0;
    end else begin
      count           <= count_nxt;
      tmr             <= tmr_nxt;
      seen_ne         <= seen_ne_nxt;
      seq_num         <= seq_nxt;
      tx_data_length  <= data_len_nxt;
      tx_total_length <= total_len_nxt;
      tx_enable       <= tx_en_nxt;
      pkt_sent        <= sent_nxt;
      timeout_cnt     <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_udp_tx_packer.sv
// Directed bench for udp_tx_packer: scoreboard of FIFO words plus a counting FIFO drain model.
module tb_udp_tx_packer;

  localparam int W    = 4;
  localparam int IFG  = 8;
  localparam int TMO  = 100;
  localparam int RSTC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [63:0] sample_data = '0;
  logic        flush = 1'b0;
  logic        etx_full = 1'b0;
  logic        etx_empty = 1'b1;
  logic        sample_ready, wr_en, tx_enable, etx_fifo_rst, pkt_sent;
  logic [63:0] etx_din;
  logic [15:0] tx_data_length, tx_total_length, seq_num;
  logic [7:0]  timeout_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] sb[$];
  int          fifo_cnt = 0;
  int          empty_mode = 0;
  bit          drain_ok = 1'b1;
  bit          bp_on = 1'b0;
  logic [15:0] exp_seq = '0;

  always #5 clk = ~clk;

  udp_tx_packer #(
    .WORDS_PER_PKT (W),
    .MAGIC         (16'hA55A),
    .IFG_CYCLES    (IFG),
    .TX_TIMEOUT    (TMO),
    .RST_CYCLES    (RSTC)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sample_valid    (sample_valid),
    .sample_data     (sample_data),
    .sample_ready    (sample_ready),
    .flush           (flush),
    .etx_full        (etx_full),
    .etx_empty       (etx_empty),
    .etx_din         (etx_din),
    .wr_en           (wr_en),
    .tx_enable       (tx_enable),
    .tx_data_length  (tx_data_length),
    .tx_total_length (tx_total_length),
    .etx_fifo_rst    (etx_fifo_rst),
    .seq_num         (seq_num),
    .pkt_sent        (pkt_sent),
    .timeout_cnt     (timeout_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor and FIFO occupancy model (one word drains per cycle while tx_enable).
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) begin
        chk("wr_en_while_full", {63'b0, etx_full}, 64'd0);
        if (sb.size() == 0) chk("sb_extra_write", 64'(sb.size()), 64'd1);
        else                chk("fifo_word", etx_din, sb.pop_front());
        fifo_cnt++;
      end
      if (etx_fifo_rst)                                  fifo_cnt = 0;
      else if (tx_enable && drain_ok && fifo_cnt > 0)    fifo_cnt--;
      etx_empty = (empty_mode == 1) ? 1'b0 : (empty_mode == 2) ? 1'b1 : (fifo_cnt == 0);
    end
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_on) begin
        ph++;
        if (ph >= 3) begin
          etx_full = ~etx_full;
          ph = 0;
        end
      end else begin
        etx_full = 1'b0;
        ph = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr();
    sb.push_back({16'hA55A, exp_seq, 32'h0});
  endtask

  task automatic send(input logic [63:0] d, input logic fl);
    int n;
    sample_valid = 1'b1;
    sample_data  = d;
    flush        = fl;
    sb.push_back(d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_ready && n < 500);
    chk("handshake", {63'b0, sample_ready}, 64'd1);
    tick();
    sample_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic wait_txen();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_enable && n < 500);
    chk("tx_enable_rise", {63'b0, tx_enable}, 64'd1);
  endtask

  task automatic wait_sent();
    int n, bad;
    n = 0;
    bad = 0;
    while (!pkt_sent && n < 2000) begin
      if (!tx_enable) bad++;
      @(negedge clk);
      n++;
    end
    chk("pkt_sent", {63'b0, pkt_sent}, 64'd1);
    chk("tx_enable_held", 64'(bad), 64'd0);
    chk("drained_before_done", 64'(fifo_cnt), 64'd0);
    chk("tx_enable_fall", {63'b0, tx_enable}, 64'd0);
    exp_seq = exp_seq + 16'd1;
    chk("seq_num", {48'b0, seq_num}, {48'b0, exp_seq});
  endtask

  initial begin
    int n;
    #1;
    chk("rst_seq", {48'b0, seq_num}, 64'd0);
    chk("rst_txen_wr_rdy_rst_sent", {59'b0, tx_enable, wr_en, sample_ready, etx_fifo_rst, pkt_sent}, 64'd0);
    chk("rst_lengths", {32'b0, tx_data_length, tx_total_length}, 64'd0);
    chk("rst_timeout_cnt", {56'b0, timeout_cnt}, 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Full packet of W words.
    hdr();
    for (int i = 1; i <= W; i++) send(64'(i), 1'b0);
    wait_txen();
    chk("full_data_len", {48'b0, tx_data_length}, 64'd48);
    chk("full_total_len", {48'b0, tx_total_length}, 64'd68);
    wait_sent();
    chk("full_len_hold", {32'b0, tx_data_length, tx_total_length}, {32'b0, 16'd48, 16'd68});

    // Flush together with the second sample.
    hdr();
    send(64'h11, 1'b0);
    send(64'h22, 1'b1);
    wait_txen();
    chk("flush_data_len", {48'b0, tx_data_length}, 64'd32);
    chk("flush_total_len", {48'b0, tx_total_length}, 64'd52);
    wait_sent();

    // etx_full toggling every 3 cycles while filling.
    bp_on = 1'b1;
    hdr();
    for (int i = 0; i < W; i++) send(64'hB0 + 64'(i), 1'b0);
    bp_on = 1'b0;
    wait_txen();
    chk("bp_data_len", {48'b0, tx_data_length}, 64'd48);
    wait_sent();

    // Hung transfer: FIFO never reports empty.
    empty_mode = 1;
    drain_ok   = 1'b0;
    hdr();
    send(64'hC1, 1'b1);
    wait_txen();
    chk("tmo_data_len", {48'b0, tx_data_length}, 64'd24);
    chk("tmo_total_len", {48'b0, tx_total_length}, 64'd44);
    n = 0;
    while (tx_enable && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_txen_cycles", 64'(n), 64'(TMO));
    n = 0;
    while (etx_fifo_rst && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_fifo_rst_cycles", 64'(n), 64'(RSTC));
    chk("tmo_timeout_cnt", {56'b0, timeout_cnt}, 64'd1);
    chk("tmo_no_pkt_sent", {63'b0, pkt_sent}, 64'd0);
    exp_seq = exp_seq + 16'd1;
    chk("tmo_seq_num", {48'b0, seq_num}, {48'b0, exp_seq});
    empty_mode = 0;
    drain_ok   = 1'b1;
    repeat (IFG + 4) tick();

    // Reset in the middle of FILL.
    hdr();
    send(64'hE1, 1'b0);
    send(64'hE2, 1'b0);
    #2;
    reset_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    chk("mid_rst_seq", {48'b0, seq_num}, 64'd0);
    chk("mid_rst_timeout_cnt", {56'b0, timeout_cnt}, 64'd0);
    chk("mid_rst_lengths", {32'b0, tx_data_length, tx_total_length}, 64'd0);
    chk("mid_rst_ctrl", {59'b0, tx_enable, wr_en, sample_ready, etx_fifo_rst, pkt_sent}, 64'd0);
    chk("mid_rst_din", etx_din, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    exp_seq = '0;
    hdr();
    send(64'hF1, 1'b1);
    wait_txen();
    chk("post_rst_data_len", {48'b0, tx_data_length}, 64'd24);
    wait_sent();
    repeat (IFG + 4) tick();

    // Sequence wrap with a stale empty at launch.
    force dut.seq_nxt = 16'hFFFF;
    tick();
    release dut.seq_nxt;
    #1;
    chk("preload_seq", {48'b0, seq_num}, 64'hFFFF);
    exp_seq    = 16'hFFFF;
    empty_mode = 2;
    drain_ok   = 1'b0;
    hdr();
    send(64'hD1, 1'b1);
    wait_txen();
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (pkt_sent || !tx_enable) n++;
    end
    chk("stale_empty_no_done", 64'(n), 64'd0);
    empty_mode = 0;
    repeat (4) tick();
    drain_ok = 1'b1;
    wait_sent();

    repeat (4) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
